// File: rtl/data_mem_responder_if.sv
// Request/response bus between the load/store datapath (master) and the data-memory
// responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_word_we;
    logic        req_byte_we;
    logic        req_byte;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_word_we, req_byte_we, req_byte, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_word_we, req_byte_we, req_byte, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request at a time, WAIT_CYCLES wait states, then a held response.
// Optional DMR_BYTE_LOAD_EN: byte reads return the zero-extended addressed lane.
module data_mem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input logic                  clock,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WORD_WR, OP_BYTE_WR} op_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        op_t         op;
        logic        byte_rd;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    req_t        lreq;
    logic [31:0] mem [DEPTH];

    logic        req_ready_q, resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    req_t            in_req, cur;
    logic            accept, enter_resp, in_range;
    logic [31:0]     off, old_word, rd_data;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [3:0][7:0] new_word;

    assign in_req.addr    = bus.req_addr;
    assign in_req.wdata   = bus.req_wdata;
    assign in_req.op      = bus.req_word_we ? OP_WORD_WR : (bus.req_byte_we ? OP_BYTE_WR : OP_READ);
    assign in_req.byte_rd = bus.req_byte;

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign cur        = (state == IDLE) ? in_req : lreq;
    assign accept     = (state == IDLE) && bus.req_valid;
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));

    assign off      = cur.addr - BASE_ADDR;
    assign in_range = (cur.addr >= BASE_ADDR) && (off[31:AW+2] == '0);
    assign idx      = off[AW+1:2];
    assign lane     = cur.addr[1:0];
    assign old_word = mem[idx];

    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign new_word[l] = (cur.op == OP_WORD_WR) ? cur.wdata[8*l +: 8] :
                             (lane == 2'(l))        ? cur.wdata[7:0]     : old_word[8*l +: 8];
    end

`ifdef DMR_BYTE_LOAD_EN
    assign rd_data = cur.byte_rd ? {24'b0, old_word[8*lane +: 8]} : old_word;
`else
    assign rd_data = old_word;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lreq         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= !in_range;
                resp_rdata_q <= (in_range && cur.op == OP_READ) ? rd_data : 32'd0;
                if (in_range && cur.op != OP_READ) mem[idx] <= new_word;
            end
            case (state)
                IDLE: if (bus.req_valid) begin
                    lreq        <= in_req;
                    req_ready_q <= 1'b0;
                    if (WAIT_CYCLES == 0) state <= RESP;
                    else begin
                        state <= WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                WAIT: if (cnt == 4'd0) state <= RESP;
                      else             cnt   <= cnt - 4'd1;
                RESP: if (bus.resp_ready) begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=256, WAIT_CYCLES=2, BASE_ADDR=0x10000000).
module tb_data_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h1000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Issue one request, count edges (accept edge included) until resp_valid, then take it.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic wwe,
                          input logic bwe, input logic bt,
                          output logic [31:0] r, output logic e, output int l);
        logic s;
        s = 1'b0;
        l = 0;
        @(negedge clock);
        bus.req_addr = a; bus.req_wdata = wd; bus.req_word_we = wwe;
        bus.req_byte_we = bwe; bus.req_byte = bt; bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        for (int i = 0; i < 40 && !s; i++) begin
            @(posedge clock); l++;
            @(negedge clock); bus.req_valid = 1'b0;
            s = bus.resp_valid;
        end
        chk("resp_seen", {31'b0, s}, 32'd1);
        r = bus.resp_rdata;
        e = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.resp_ready = 1'b0;
    endtask

    task automatic rd_word(input string tag, input logic [31:0] a, input logic bt,
                           input logic [31:0] exp, input logic exp_err);
        logic [31:0] r; logic e; int l;
        do_req(a, 32'd0, 1'b0, 1'b0, bt, r, e, l);
        chk({tag, "_rdata"}, r, exp);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic wwe, input logic bwe, input logic exp_err);
        logic [31:0] r; logic e; int l;
        do_req(a, wd, wwe, bwe, 1'b0, r, e, l);
        chk({tag, "_ack_rdata"}, r, 32'd0);
        chk({tag, "_ack_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    initial begin
        bus.req_valid = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_word_we = 0;
        bus.req_byte_we = 0; bus.req_byte = 0; bus.resp_ready = 0;

        // 1: reset state, first read latency
        repeat (2) @(negedge clock);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", {31'b0, bus.resp_err}, 32'd0);
        reset = 1'b1;
        do_req(32'h1000_0000, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("rd0_latency", 32'(lat), 32'd3);
        chk("rd0_rdata", rd, 32'd0);
        chk("rd0_err", {31'b0, er}, 32'd0);

        // 2: word write then read back
        wr("ww4", 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        rd_word("rd4", 32'h1000_0004, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // 3: byte write to lane 2 (upper wdata bits must not leak), word/byte precedence
        wr("bw6", 32'h1000_0006, 32'hFFFF_FF5A, 1'b0, 1'b1, 1'b0);
        rd_word("rd4_after_bw", 32'h1000_0004, 1'b0, 32'hDE5A_BEEF, 1'b0);
        rd_word("rd7_unaligned", 32'h1000_0007, 1'b0, 32'hDE5A_BEEF, 1'b0);
`ifdef DMR_BYTE_LOAD_EN
        rd_word("lbu6", 32'h1000_0006, 1'b1, 32'h0000_005A, 1'b0);
        rd_word("lbu4", 32'h1000_0004, 1'b1, 32'h0000_00EF, 1'b0);
`else
        rd_word("byte_flag_ignored", 32'h1000_0006, 1'b1, 32'hDE5A_BEEF, 1'b0);
`endif
        wr("both_we", 32'h1000_0008, 32'h1122_3344, 1'b1, 1'b1, 1'b0);
        rd_word("rd8", 32'h1000_0008, 1'b0, 32'h1122_3344, 1'b0);

        // 4: response held under backpressure; a competing request is ignored
        @(negedge clock);
        bus.req_addr = 32'h1000_0004; bus.req_word_we = 0; bus.req_byte_we = 0; bus.req_byte = 0;
        bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            @(negedge clock); bus.req_valid = 1'b0;
            seen = bus.resp_valid;
        end
        chk("hold_resp_seen", {31'b0, seen}, 32'd1);
        bus.req_valid = 1'b1; bus.req_word_we = 1'b1; bus.req_wdata = 32'd0;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
            chk("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
            chk("hold_rdata", bus.resp_rdata, 32'hDE5A_BEEF);
            chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0; bus.req_word_we = 1'b0; bus.resp_ready = 1'b0;
        chk("release_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("release_req_ready", {31'b0, bus.req_ready}, 32'd1);
        rd_word("rd4_not_overwritten", 32'h1000_0004, 1'b0, 32'hDE5A_BEEF, 1'b0);

        // 5: range boundaries
        do_req(32'h0FFF_FFFC, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("below_latency", 32'(lat), 32'd3);
        chk("below_rdata", rd, 32'd0);
        chk("below_err", {31'b0, er}, 32'd1);
        rd_word("above", 32'h1000_0400, 1'b0, 32'd0, 1'b1);
        wr("wr_above", 32'h1000_0400, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        wr("wr_below", 32'h0FFF_FFFC, 32'h8765_4321, 1'b1, 1'b0, 1'b1);
        rd_word("word0_unchanged", 32'h1000_0000, 1'b0, 32'd0, 1'b0);
        rd_word("last_unchanged", 32'h1000_03FC, 1'b0, 32'd0, 1'b0);
        wr("wr_last", 32'h1000_03FF, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        rd_word("rd_last", 32'h1000_03FC, 1'b0, 32'hCAFE_F00D, 1'b0);

        // 6: reset in the middle of a write's wait states
        @(negedge clock);
        bus.req_addr = 32'h1000_0010; bus.req_wdata = 32'h0BAD_F00D; bus.req_word_we = 1'b1;
        bus.req_byte_we = 1'b0; bus.req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0; bus.req_word_we = 1'b0;
        chk("pre_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("post_rst_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        end
        rd_word("rd10_after_rst", 32'h1000_0010, 1'b0, 32'd0, 1'b0);
        rd_word("rd4_after_rst", 32'h1000_0004, 1'b0, 32'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
